lc3_mem_arbiter: RTL



---
 rtl/lc3_mem_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lc3_mem_arbiter.sv
// Serializes LC3 instruction fetches and data accesses onto one req/ack memory bus, data first.
// Optional LC3_MEM_TIMEOUT_EN abandons accesses after TIMEOUT unacknowledged cycles.
module lc3_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instrmem_rd,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic              data_en,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic              Data_rd,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err
);

    typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;

    localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(16'hDEAD);

    state_t            state_reg, state_next;
    logic              accept_data, accept_instr, timeout_hit, finish;
    logic              mem_req_next, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next, instr_dout_next, data_dout_next;
    logic              complete_instr_next, complete_data_next;

    // A requester whose completion is visible this cycle is still holding its
    // request line; blocking it here prevents a duplicate access.
    assign accept_data  = data_en && !complete_data;
    assign accept_instr = instrmem_rd && !complete_instr && !accept_data;
    assign finish       = mem_ack || timeout_hit;

`ifdef LC3_MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (state_reg != IDLE) && !mem_ack && (wait_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (state_reg == IDLE || mem_ack) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept_data) begin
                    state_next = DBUS;
                end else if (accept_instr) begin
                    state_next = IBUS;
                end
            end
            IBUS, DBUS: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_next        = mem_req;
        mem_we_next         = mem_we;
        mem_addr_next       = mem_addr;
        mem_wdata_next      = mem_wdata;
        instr_dout_next     = Instr_dout;
        data_dout_next      = Data_dout;
        complete_instr_next = 1'b0;
        complete_data_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept_data) begin
                    mem_req_next   = 1'b1;
                    mem_we_next    = !Data_rd;
                    mem_addr_next  = Data_addr;
                    mem_wdata_next = Data_din;
                end else if (accept_instr) begin
                    mem_req_next  = 1'b1;
                    mem_we_next   = 1'b0;
                    mem_addr_next = pc;
                end
            end
            IBUS: begin
                if (finish) begin
                    mem_req_next        = 1'b0;
                    complete_instr_next = 1'b1;
                    instr_dout_next     = mem_ack ? mem_rdata : ABORT_WORD;
                end
            end
            DBUS: begin
                if (finish) begin
                    mem_req_next       = 1'b0;
                    complete_data_next = 1'b1;
                    if (!mem_we) begin
                        data_dout_next = mem_ack ? mem_rdata : ABORT_WORD;
                    end
                end
            end
            default: mem_req_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            Instr_dout     <= '0;
            Data_dout      <= '0;
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
        end else begin
            mem_req        <= mem_req_next;
            mem_we         <= mem_we_next;
            mem_addr       <= mem_addr_next;
            mem_wdata      <= mem_wdata_next;
            Instr_dout     <= instr_dout_next;
            Data_dout      <= data_dout_next;
            complete_instr <= complete_instr_next;
            complete_data  <= complete_data_next;
        end
    end

endmodule
